// File: rtl/apb_pkg.sv
// Shared types and widths for the two-requester APB master.
package apb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // APB transfer phases seen by the master FSM.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter: picks a requester and flips priority after each grant.
module apb_rr_arb
    import apb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_idx
);

    logic r_ptr;

    // A lone request wins outright; on a tie the pointer decides.
    always_comb begin
        o_valid = |i_req;
        o_idx   = (i_req == 2'b11) ? r_ptr : i_req[1];
    end

    // After every grant, the other requester gets priority next time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_update && o_valid) begin
            r_ptr <= ~o_idx;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters, with round-robin arbitration and a
// wait-state timeout that aborts a transfer whose slave never becomes ready.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    // A zero TIMEOUT still needs a legal one-bit counter; it is simply never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    apb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gnt;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_done;
    logic              r_err;

    logic [1:0]        w_arb_req;
    logic              w_arb_valid;
    logic              w_arb_idx;
    logic              w_take;
    logic              w_timeout;
    logic              w_wr_sel;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;

    // At a completion edge only the other requester may be granted, so the
    // one just served sees its done pulse before its req is looked at again.
    always_comb begin
        w_arb_req   = (r_state == ST_ACCESS) ? (req & (r_gnt ? 2'b01 : 2'b10)) : req;
        w_take      = w_arb_valid &&
                      ((r_state == ST_IDLE) || ((r_state == ST_ACCESS) && pready));
        w_timeout   = (TIMEOUT > 0) && (r_cnt == CNT_LIMIT) && !pready;
        w_wr_sel    = wr[w_arb_idx];
        w_addr_sel  = w_arb_idx ? addr1 : addr0;
        w_wdata_sel = w_arb_idx ? wdata1 : wdata0;
    end

    apb_rr_arb u_arb (
        .i_clk    (pclk),
        .i_rst_n  (presetn),
        .i_req    (w_arb_req),
        .i_update (w_take),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx)
    );

    // Transfer sequencing, operand capture, wait counting and completion pulses.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_gnt    <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_gnt    <= w_arb_idx;
                        r_pwrite <= w_wr_sel;
                        r_paddr  <= w_addr_sel;
                        r_pwdata <= w_wdata_sel;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_done[r_gnt] <= 1'b1;
                        r_cnt         <= '0;
                        if (!r_pwrite) begin
                            r_rdata <= prdata;
                        end
                        if (w_take) begin
                            r_gnt    <= w_arb_idx;
                            r_pwrite <= w_wr_sel;
                            r_paddr  <= w_addr_sel;
                            r_pwdata <= w_wdata_sel;
                            r_state  <= ST_SETUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_done[r_gnt] <= 1'b1;
                        r_err         <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // APB strobes follow the phase directly so reset drops them at once.
    always_comb begin
        psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        penable = (r_state == ST_ACCESS);
        pwrite  = r_pwrite;
        paddr   = r_paddr;
        pwdata  = r_pwdata;
        rdata   = r_rdata;
        done    = r_done;
        err     = r_err;
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master built with TIMEOUT=4.
module tb_apb_arb_master;

    logic       pclk;
    logic       presetn;
    logic [1:0] req;
    logic [1:0] wr;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] done;
    logic       err;
    logic [7:0] rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready;

    int total = 0;
    int bad   = 0;

    apb_arb_master #(.TIMEOUT(4)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req),
        .wr      (wr),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready)
    );

    // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic test_reset;
        presetn = 1'b0; req = 2'b00; wr = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        prdata = 8'h00; pready = 1'b0;
        #1;
        total++; if ({psel, penable, pwrite, paddr, pwdata, rdata, done, err} !== 30'h0) begin bad++; $display("[TB] FAIL reset_outputs: got %h expected 0", {psel, penable, pwrite, paddr, pwdata, rdata, done, err}); end
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        total++; if ({psel, done, err} !== 4'b0) begin bad++; $display("[TB] FAIL reset_idle: got %b expected 0000", {psel, done, err}); end
    endtask

    task automatic test_write_zero_wait;
        req = 2'b01; wr = 2'b01; addr0 = 8'h12; wdata0 = 8'hA5; pready = 1'b1;
        @(negedge pclk);
        total++; if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 8'h12, 8'hA5}) begin bad++; $display("[TB] FAIL wr_setup: got %h expected %h", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b0, 1'b1, 8'h12, 8'hA5}); end
        @(negedge pclk);
        total++; if ({psel, penable, paddr, pwdata, done} !== {1'b1, 1'b1, 8'h12, 8'hA5, 2'b00}) begin bad++; $display("[TB] FAIL wr_access: got %h expected %h", {psel, penable, paddr, pwdata, done}, {1'b1, 1'b1, 8'h12, 8'hA5, 2'b00}); end
        @(negedge pclk);
        req = 2'b00;
        total++; if ({done, err, psel, rdata} !== {2'b01, 1'b0, 1'b0, 8'h00}) begin bad++; $display("[TB] FAIL wr_done: got %h expected %h", {done, err, psel, rdata}, {2'b01, 1'b0, 1'b0, 8'h00}); end
        @(negedge pclk);
        total++; if ({done, psel} !== 3'b000) begin bad++; $display("[TB] FAIL wr_done_pulse: got %b expected 000", {done, psel}); end
    endtask

    task automatic test_read_wait;
        req = 2'b10; wr = 2'b00; addr1 = 8'h05; pready = 1'b0; prdata = 8'h99;
        @(negedge pclk);
        total++; if ({psel, penable, pwrite, paddr} !== {1'b1, 1'b0, 1'b0, 8'h05}) begin bad++; $display("[TB] FAIL rd_setup: got %h expected %h", {psel, penable, pwrite, paddr}, {1'b1, 1'b0, 1'b0, 8'h05}); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge pclk);
            total++; if ({penable, done} !== 3'b100) begin bad++; $display("[TB] FAIL rd_access_%0d: got %b expected 100", i, {penable, done}); end
            if (i == 4) begin pready = 1'b1; prdata = 8'h3C; end
        end
        @(negedge pclk);
        req = 2'b00; pready = 1'b0;
        total++; if ({done, err, rdata, psel} !== {2'b10, 1'b0, 8'h3C, 1'b0}) begin bad++; $display("[TB] FAIL rd_done: got %h expected %h", {done, err, rdata, psel}, {2'b10, 1'b0, 8'h3C, 1'b0}); end
    endtask

    task automatic test_back_to_back;
        // Reset first so the pointer favours requester 0.
        @(negedge pclk); presetn = 1'b0;
        @(negedge pclk); presetn = 1'b1;
        req = 2'b11; wr = 2'b01; addr0 = 8'h20; wdata0 = 8'h11; addr1 = 8'h30; wdata1 = 8'h22;
        pready = 1'b1; prdata = 8'h77;
        @(negedge pclk);
        total++; if ({psel, penable, paddr} !== {1'b1, 1'b0, 8'h20}) begin bad++; $display("[TB] FAIL b2b_first_setup: got %h expected %h", {psel, penable, paddr}, {1'b1, 1'b0, 8'h20}); end
        @(negedge pclk);
        total++; if ({penable, paddr, pwrite} !== {1'b1, 8'h20, 1'b1}) begin bad++; $display("[TB] FAIL b2b_first_access: got %h expected %h", {penable, paddr, pwrite}, {1'b1, 8'h20, 1'b1}); end
        @(negedge pclk);
        total++; if ({done, psel, penable, paddr, pwrite} !== {2'b01, 1'b1, 1'b0, 8'h30, 1'b0}) begin bad++; $display("[TB] FAIL b2b_second_setup: got %h expected %h", {done, psel, penable, paddr, pwrite}, {2'b01, 1'b1, 1'b0, 8'h30, 1'b0}); end
        @(negedge pclk);
        total++; if ({done, penable, paddr} !== {2'b00, 1'b1, 8'h30}) begin bad++; $display("[TB] FAIL b2b_second_access: got %h expected %h", {done, penable, paddr}, {2'b00, 1'b1, 8'h30}); end
        @(negedge pclk);
        // Requester 0 is regranted here; dropping req now must not cancel it.
        req = 2'b00;
        total++; if ({done, psel, penable, paddr, rdata} !== {2'b10, 1'b1, 1'b0, 8'h20, 8'h77}) begin bad++; $display("[TB] FAIL b2b_third_setup: got %h expected %h", {done, psel, penable, paddr, rdata}, {2'b10, 1'b1, 1'b0, 8'h20, 8'h77}); end
        repeat (2) @(negedge pclk);
        total++; if ({done, err, psel} !== {2'b01, 1'b0, 1'b0}) begin bad++; $display("[TB] FAIL b2b_third_done: got %b expected 0100", {done, err, psel}); end
        pready = 1'b0;
    endtask

    task automatic test_timeout;
        req = 2'b01; wr = 2'b00; addr0 = 8'h40; pready = 1'b0; prdata = 8'hEE;
        repeat (2) @(negedge pclk);
        for (int i = 1; i <= 5; i++) begin
            total++; if ({psel, penable, done} !== 4'b1100) begin bad++; $display("[TB] FAIL to_wait_%0d: got %b expected 1100", i, {psel, penable, done}); end
            @(negedge pclk);
        end
        req = 2'b00;
        total++; if ({done, err, psel, penable, rdata} !== {2'b01, 1'b1, 1'b0, 1'b0, 8'h77}) begin bad++; $display("[TB] FAIL to_abort: got %h expected %h", {done, err, psel, penable, rdata}, {2'b01, 1'b1, 1'b0, 1'b0, 8'h77}); end
        @(negedge pclk);
        total++; if ({done, err} !== 3'b000) begin bad++; $display("[TB] FAIL to_err_clear: got %b expected 000", {done, err}); end
    endtask

    task automatic test_timeout_race;
        req = 2'b10; wr = 2'b00; addr1 = 8'h50; pready = 1'b0; prdata = 8'h5A;
        repeat (2) @(negedge pclk);
        repeat (4) @(negedge pclk);
        pready = 1'b1;
        total++; if ({penable, done} !== 3'b100) begin bad++; $display("[TB] FAIL race_pending: got %b expected 100", {penable, done}); end
        @(negedge pclk);
        req = 2'b00; pready = 1'b0;
        total++; if ({done, err, rdata} !== {2'b10, 1'b0, 8'h5A}) begin bad++; $display("[TB] FAIL race_done: got %h expected %h", {done, err, rdata}, {2'b10, 1'b0, 8'h5A}); end
    endtask

    task automatic test_reset_mid;
        req = 2'b01; wr = 2'b01; addr0 = 8'h61; wdata0 = 8'h0F; addr1 = 8'h62; pready = 1'b0;
        repeat (2) @(negedge pclk);
        total++; if (penable !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_access: got %b expected 1", penable); end
        #2 presetn = 1'b0;
        #1;
        total++; if ({psel, penable, pwrite, paddr, pwdata, rdata, done, err} !== 30'h0) begin bad++; $display("[TB] FAIL rst_mid_outputs: got %h expected 0", {psel, penable, pwrite, paddr, pwdata, rdata, done, err}); end
        pready = 1'b1;
        @(negedge pclk);
        total++; if ({done, psel} !== 3'b000) begin bad++; $display("[TB] FAIL rst_mid_no_done: got %b expected 000", {done, psel}); end
        presetn = 1'b1; req = 2'b11; wr = 2'b00;
        @(negedge pclk);
        total++; if ({psel, paddr} !== {1'b1, 8'h61}) begin bad++; $display("[TB] FAIL rst_mid_priority: got %h expected %h", {psel, paddr}, {1'b1, 8'h61}); end
        repeat (2) @(negedge pclk);
        req = 2'b00;
        total++; if ({done, err} !== 3'b010) begin bad++; $display("[TB] FAIL rst_mid_regrant_done: got %b expected 010", {done, err}); end
    endtask

    // Scenarios run in order; each leaves the bus idle for the next.
    initial begin
        test_reset;
        test_write_zero_wait;
        test_read_wait;
        test_back_to_back;
        test_timeout;
        test_timeout_race;
        test_reset_mid;
        repeat (3) @(negedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
